// File: rtl/idli_pkg.sv
// idli_pkg: shared types for the idli core trace path.
//   ctr_t     - core sync counter (0 = first GCK of a period, all-ones = last)
//   reg_t     - GPR index
//   data_t    - PC / data word
//   trc_rec_t - retire trace record {pc, reg_mask, pred_wr, seq}
package idli_pkg;

   localparam int NUM_REGS  = 16;
   localparam int DATA_W    = 16;
   localparam int CTR_W     = 2;
   localparam int TRC_SEQ_W = 16;

   typedef logic [CTR_W-1:0]            ctr_t;
   typedef logic [$clog2(NUM_REGS)-1:0] reg_t;
   typedef logic [DATA_W-1:0]           data_t;

   typedef struct packed {
      data_t                pc;
      logic [NUM_REGS-1:0]  reg_mask;
      logic                 pred_wr;
      logic [TRC_SEQ_W-1:0] seq;
   } trc_rec_t;

   localparam int TRC_REC_W = $bits(trc_rec_t);

endpackage

// File: rtl/idli_trace_fifo_m.sv
// idli_trace_fifo_m: registered FIFO with valid/ready pop and drop-on-full push.
//   i_clk, i_rst_n - clock, async active-low reset
//   i_push, i_data - push strobe and payload (W bits)
//   o_vld, i_rdy   - head valid / consumer ready; pop on o_vld && i_rdy
//   o_data         - head payload
//   o_level        - occupancy, 0..DEPTH
//   o_drop         - push discarded this cycle (full and no pop)
module idli_trace_fifo_m #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_rdy,
   output logic                     o_vld,
   output logic [W-1:0]             o_data,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [LW-1:0] r_level;

   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_full = (r_level == LW'(DEPTH));
   assign w_pop  = (r_level != '0) && i_rdy;
   // When full, a same-cycle pop frees the slot the write lands in.
   assign w_push = i_push && (!w_full || w_pop);
   assign o_drop = i_push && w_full && !w_pop;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage is deliberately left unreset; content is don't-care while empty.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   assign o_data  = r_mem[r_rptr];
   assign o_vld   = (r_level != '0);
   assign o_level = r_level;

endmodule

// File: rtl/idli_trace_m.sv
// idli_trace_m: retire trace capture for the idli core.
// Accumulates PC, written-GPR mask and predicate-write flag over the periods
// of one instruction and pushes a sequenced record into a trace FIFO on retire.
//   i_trc_gck, i_trc_rst_n           - clock, async active-low reset
//   i_trc_ctr                        - core sync counter
//   i_trc_run_instr                  - EX executing current instruction
//   i_trc_mem_op, i_trc_mem_op_last  - multi-period memory op / its final period
//   i_trc_dst_reg_wr, i_trc_dst_reg  - GPR write strobe and index
//   i_trc_dst_p, i_trc_skip          - predicate destination / instruction skipped
//   i_trc_enc_vld, i_trc_enc_new     - new valid encoding in EX
//   i_trc_pc                         - PC of instruction in EX
//   o_trc_vld, i_trc_rdy, o_trc_rec  - trace record stream
//   o_trc_level                      - FIFO occupancy
//   o_trc_ovf, i_trc_ovf_clr         - sticky overflow flag and clear
module idli_trace_m
   import idli_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SEQ_W = TRC_SEQ_W
) (
   input  logic                    i_trc_gck,
   input  logic                    i_trc_rst_n,
   input  ctr_t                    i_trc_ctr,
   input  logic                    i_trc_run_instr,
   input  logic                    i_trc_mem_op,
   input  logic                    i_trc_mem_op_last,
   input  logic                    i_trc_dst_reg_wr,
   input  reg_t                    i_trc_dst_reg,
   input  logic                    i_trc_dst_p,
   input  logic                    i_trc_skip,
   input  logic                    i_trc_enc_vld,
   input  logic                    i_trc_enc_new,
   input  data_t                   i_trc_pc,
   output logic                    o_trc_vld,
   input  logic                    i_trc_rdy,
   output trc_rec_t                o_trc_rec,
   output logic [$clog2(DEPTH):0]  o_trc_level,
   output logic                    o_trc_ovf,
   input  logic                    i_trc_ovf_clr
);

   data_t               r_pc;
   logic [NUM_REGS-1:0] r_mask;
   logic                r_pred;
   logic [SEQ_W-1:0]    r_seq;
   logic                r_ovf;

   logic                w_ctr0;
   logic                w_done;
   logic [NUM_REGS-1:0] w_bit;
   logic                w_drop;
   trc_rec_t            w_push_rec;

   assign w_ctr0 = (i_trc_ctr == '0);
   assign w_done = (&i_trc_ctr) && i_trc_run_instr && (!i_trc_mem_op || i_trc_mem_op_last);
   assign w_bit  = NUM_REGS'(1) << i_trc_dst_reg;

   always_comb begin
      w_push_rec          = '0;
      w_push_rec.pc       = r_pc;
      w_push_rec.reg_mask = r_mask;
      w_push_rec.pred_wr  = r_pred;
      w_push_rec.seq      = TRC_SEQ_W'(r_seq);
   end

   always_ff @(posedge i_trc_gck or negedge i_trc_rst_n) begin
      if (!i_trc_rst_n) begin
         r_pc   <= '0;
         r_mask <= '0;
         r_pred <= 1'b0;
         r_seq  <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_ctr0 && i_trc_enc_vld && i_trc_enc_new) r_pc <= i_trc_pc;

         // Retire and capture never share an edge (ctr all-ones vs zero);
         // pc is intentionally held across retire.
         if (w_done) begin
            r_mask <= '0;
            r_pred <= 1'b0;
            r_seq  <= r_seq + SEQ_W'(1);
         end else if (w_ctr0) begin
            if (i_trc_dst_reg_wr)               r_mask <= r_mask | w_bit;
            if (i_trc_run_instr && i_trc_dst_p) r_pred <= !i_trc_skip;
         end

         // A new overflow wins over a same-edge clear.
         if (w_drop)             r_ovf <= 1'b1;
         else if (i_trc_ovf_clr) r_ovf <= 1'b0;
      end
   end

   idli_trace_fifo_m #(
      .DEPTH (DEPTH),
      .W     (TRC_REC_W)
   ) u_fifo (
      .i_clk   (i_trc_gck),
      .i_rst_n (i_trc_rst_n),
      .i_push  (w_done),
      .i_data  (w_push_rec),
      .i_rdy   (i_trc_rdy),
      .o_vld   (o_trc_vld),
      .o_data  (o_trc_rec),
      .o_level (o_trc_level),
      .o_drop  (w_drop)
   );

   assign o_trc_ovf = r_ovf;

endmodule

// File: tb/tb_idli_trace_m.sv
module tb_idli_trace_m;
   import idli_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ctr_t  ctr;
   logic  run, mo, ml, wr, dp, sk, ev, en, rdy, clr;
   reg_t  rg;
   data_t pc;

   logic                   vld, ovf;
   trc_rec_t               rec;
   logic [$clog2(DEPTH):0] level;

   int n_cmp = 0;
   int n_bad = 0;

   idli_trace_m #(.DEPTH(DEPTH), .SEQ_W(TRC_SEQ_W)) dut (
      .i_trc_gck         (clk),
      .i_trc_rst_n       (rst_n),
      .i_trc_ctr         (ctr),
      .i_trc_run_instr   (run),
      .i_trc_mem_op      (mo),
      .i_trc_mem_op_last (ml),
      .i_trc_dst_reg_wr  (wr),
      .i_trc_dst_reg     (rg),
      .i_trc_dst_p       (dp),
      .i_trc_skip        (sk),
      .i_trc_enc_vld     (ev),
      .i_trc_enc_new     (en),
      .i_trc_pc          (pc),
      .o_trc_vld         (vld),
      .i_trc_rdy         (rdy),
      .o_trc_rec         (rec),
      .o_trc_level       (level),
      .o_trc_ovf         (ovf),
      .i_trc_ovf_clr     (clr)
   );

   typedef struct {
      ctr_t  ctr;
      logic  run, mo, ml, wr;
      reg_t  rg;
      logic  dp, sk, ev, en;
      data_t pc;
      logic  rdy, clr;
   } cyc_t;

   typedef struct {
      data_t       pc;
      logic        wr;
      reg_t        rg;
      reg_t        rg_last;
      int          periods;
      logic        dp, sk;
      logic [15:0] e_mask;
      logic        e_pred;
   } ivec_t;

   // Reference model: record queue plus instruction accumulator.
   trc_rec_t    q[$];
   data_t       m_pc;
   logic [15:0] m_mask;
   logic        m_pred;
   logic [15:0] m_seq;
   logic        m_ovf;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc = '0; m_mask = '0; m_pred = 1'b0; m_seq = '0; m_ovf = 1'b0;
   endtask

   task automatic model_step(input cyc_t c);
      trc_rec_t r;
      logic done, pop, drop;
      done = (c.ctr == 2'd3) && c.run && (!c.mo || c.ml);
      pop  = (q.size() != 0) && c.rdy;
      drop = 1'b0;
      if (c.ctr == 2'd0) begin
         if (c.ev && c.en)  m_pc = c.pc;
         if (c.wr)          m_mask[c.rg] = 1'b1;
         if (c.run && c.dp) m_pred = !c.sk;
      end
      if (pop) void'(q.pop_front());
      if (done) begin
         r.pc = m_pc; r.reg_mask = m_mask; r.pred_wr = m_pred; r.seq = m_seq;
         if (q.size() >= DEPTH) drop = 1'b1;
         else q.push_back(r);
         m_mask = '0; m_pred = 1'b0; m_seq = m_seq + 16'd1;
      end
      if (drop)       m_ovf = 1'b1;
      else if (c.clr) m_ovf = 1'b0;
   endtask

   task automatic check_model();
      check("vld", vld, q.size() != 0);
      check("level", level, q.size());
      check("ovf", ovf, m_ovf);
      if (q.size() != 0) begin
         check("rec_pc", rec.pc, q[0].pc);
         check("rec_mask", rec.reg_mask, q[0].reg_mask);
         check("rec_pred", rec.pred_wr, q[0].pred_wr);
         check("rec_seq", rec.seq, q[0].seq);
      end
   endtask

   task automatic cyc(input cyc_t c);
      ctr = c.ctr; run = c.run; mo = c.mo; ml = c.ml; wr = c.wr; rg = c.rg;
      dp = c.dp; sk = c.sk; ev = c.ev; en = c.en; pc = c.pc; rdy = c.rdy; clr = c.clr;
      @(posedge clk);
      model_step(c);
      #1;
      check_model();
   endtask

   function automatic cyc_t idle(input logic r, input logic c);
      cyc_t x;
      x = '{default: '0};
      x.rdy = r;
      x.clr = c;
      return x;
   endfunction

   task automatic run_i(input ivec_t v, input logic r, input logic r_d, input logic c_d);
      cyc_t c;
      for (int p = 0; p < v.periods; p++) begin
         for (int k = 0; k < 4; k++) begin
            c = '{default: '0};
            c.ctr = ctr_t'(k);
            c.run = 1'b1;
            c.mo  = (v.periods > 1);
            c.ml  = (p == v.periods - 1);
            c.ev  = 1'b1;
            c.en  = (p == 0);
            c.pc  = v.pc;
            c.wr  = v.wr && (k == 0) && ((p == 0) || (p == v.periods - 1));
            c.rg  = (p == 0) ? v.rg : v.rg_last;
            c.dp  = v.dp && (k == 0) && (p == 0);
            c.sk  = v.sk;
            c.rdy = (p == v.periods - 1 && k == 3) ? r_d : r;
            c.clr = (p == v.periods - 1 && k == 3) ? c_d : 1'b0;
            cyc(c);
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_vld", vld, 1'b0);
      check("rst_level", level, 0);
      check("rst_ovf", ovf, 1'b0);
      model_reset();
      #3;
      rst_n = 1'b1;
   endtask

   ivec_t tbl[6];
   ivec_t alu;

   initial begin
      cyc_t c;
      int   rmode;

      tbl[0] = '{16'h0040, 1'b1, 4'd3,  4'd3,  1, 1'b0, 1'b0, 16'h0008, 1'b0};
      tbl[1] = '{16'h0100, 1'b1, 4'd5,  4'd5,  3, 1'b0, 1'b0, 16'h0020, 1'b0};
      tbl[2] = '{16'h0104, 1'b0, 4'd0,  4'd0,  1, 1'b1, 1'b1, 16'h0000, 1'b0};
      tbl[3] = '{16'h0108, 1'b0, 4'd0,  4'd0,  1, 1'b1, 1'b0, 16'h0000, 1'b1};
      tbl[4] = '{16'h010C, 1'b1, 4'd15, 4'd15, 1, 1'b0, 1'b0, 16'h8000, 1'b0};
      tbl[5] = '{16'h0110, 1'b1, 4'd0,  4'd7,  2, 1'b1, 1'b0, 16'h0081, 1'b1};
      alu    = '{16'h0200, 1'b1, 4'd1,  4'd1,  1, 1'b0, 1'b0, 16'h0002, 1'b0};

      c = idle(1'b0, 1'b0);
      ctr = c.ctr; run = 0; mo = 0; ml = 0; wr = 0; rg = '0; dp = 0; sk = 0;
      ev = 0; en = 0; pc = '0; rdy = 0; clr = 0;
      model_reset();
      @(posedge clk); #1;
      do_reset();

      // Table of single instructions, consumer always ready.
      for (int i = 0; i < 6; i++) begin
         run_i(tbl[i], 1'b1, 1'b1, 1'b0);
         check("tbl_vld", vld, 1'b1);
         check("tbl_pc", rec.pc, tbl[i].pc);
         check("tbl_mask", rec.reg_mask, tbl[i].e_mask);
         check("tbl_pred", rec.pred_wr, tbl[i].e_pred);
         check("tbl_seq", rec.seq, i);
      end
      cyc(idle(1'b1, 1'b0));
      check("tbl_drained", level, 0);

      // Five retires into a stalled FIFO: fifth dropped, overflow set.
      do_reset();
      for (int i = 0; i < 5; i++) run_i(alu, 1'b0, 1'b0, 1'b0);
      check("ovf_level", level, 4);
      check("ovf_flag", ovf, 1'b1);
      check("ovf_head", rec.seq, 0);
      for (int k = 1; k < 4; k++) begin
         cyc(idle(1'b1, 1'b0));
         check("ovf_drain_seq", rec.seq, k);
      end
      cyc(idle(1'b1, 1'b0));
      check("ovf_drain_empty", level, 0);
      check("ovf_sticky", ovf, 1'b1);

      // Full FIFO, retire coincident with pop.
      do_reset();
      for (int i = 0; i < 4; i++) run_i(alu, 1'b0, 1'b0, 1'b0);
      run_i(alu, 1'b0, 1'b1, 1'b0);
      check("fullpop_level", level, 4);
      check("fullpop_ovf", ovf, 1'b0);
      check("fullpop_head", rec.seq, 1);
      for (int k = 0; k < 3; k++) cyc(idle(1'b1, 1'b0));
      check("fullpop_tail", rec.seq, 4);
      cyc(idle(1'b1, 1'b0));
      check("fullpop_empty", vld, 1'b0);

      // Clear coincident with overflow: stays set; later clear alone works.
      do_reset();
      for (int i = 0; i < 4; i++) run_i(alu, 1'b0, 1'b0, 1'b0);
      run_i(alu, 1'b0, 1'b0, 1'b1);
      check("clr_vs_ovf", ovf, 1'b1);
      cyc(idle(1'b0, 1'b1));
      check("clr_alone", ovf, 1'b0);
      for (int k = 0; k < 4; k++) cyc(idle(1'b1, 1'b0));

      // Reset mid-instruction discards partial accumulation.
      do_reset();
      c = '{default: '0};
      c.run = 1'b1; c.ev = 1'b1; c.en = 1'b1; c.pc = 16'h0222; c.wr = 1'b1; c.rg = 4'd9;
      c.dp = 1'b1;
      cyc(c);
      c.wr = 1'b0; c.en = 1'b0; c.dp = 1'b0;
      c.ctr = 2'd1; cyc(c);
      c.ctr = 2'd2; cyc(c);
      do_reset();
      alu.pc = 16'h0300; alu.wr = 1'b0;
      run_i(alu, 1'b1, 1'b1, 1'b0);
      check("rst_mid_seq", rec.seq, 0);
      check("rst_mid_mask", rec.reg_mask, 0);
      check("rst_mid_pred", rec.pred_wr, 1'b0);
      check("rst_mid_pc", rec.pc, 16'h0300);

      // Randomized traffic against the model.
      rmode = 2;
      for (int i = 0; i < 3000; i++) begin
         if (i % 16 == 0) rmode = $urandom_range(0, 2);
         if (i == 1500) do_reset();
         c.ctr = ctr_t'(i);
         c.run = ($urandom_range(0, 7) != 0);
         c.mo  = ($urandom_range(0, 2) == 0);
         c.ml  = 1'($urandom);
         c.wr  = 1'($urandom);
         c.rg  = reg_t'($urandom);
         c.dp  = 1'($urandom);
         c.sk  = 1'($urandom);
         c.ev  = 1'($urandom);
         c.en  = 1'($urandom);
         c.pc  = data_t'($urandom);
         c.rdy = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom);
         c.clr = ($urandom_range(0, 15) == 0);
         cyc(c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/idli_trace_m.md
IDLI_TRACE_M -- requirements
Module: idli_trace_m

Interface
REQ-001 Parameter DEPTH, default 4: trace FIFO entries; power of two, minimum 2.
REQ-002 Parameter SEQ_W, default 16: width of retire sequence number.
REQ-003 Port i_trc_gck  in  1: single clock; all state on posedge.
REQ-004 Port i_trc_rst_n  in  1: reset, asynchronous, active-low.
REQ-005 Port i_trc_ctr  in  ctr_t: core sync counter; 0 = first GCK of period, all-ones = last.
REQ-006 Port i_trc_run_instr  in  1: EX is executing the current instruction.
REQ-007 Port i_trc_mem_op / i_trc_mem_op_last  in  1 each: multi-period memory op; final period flag.
REQ-008 Port i_trc_dst_reg_wr  in  1; i_trc_dst_reg  in  reg_t: GPR write strobe and index.
REQ-009 Port i_trc_dst_p  in  1; i_trc_skip  in  1: destination is predicate; instruction skipped.
REQ-010 Port i_trc_enc_vld / i_trc_enc_new  in  1 each: valid and new encoding in EX.
REQ-011 Port i_trc_pc  in  data_t: PC of instruction in EX.
REQ-012 Port o_trc_vld  out  1; i_trc_rdy  in  1: trace record handshake; pop on vld && rdy.
REQ-013 Port o_trc_rec  out  trc_rec_t: head record {pc, reg_mask[NUM_REGS], pred_wr, seq[SEQ_W]}.
REQ-014 Port o_trc_level  out  $clog2(DEPTH)+1: FIFO occupancy.
REQ-015 Port o_trc_ovf  out  1; i_trc_ovf_clr  in  1: sticky overflow flag and its clear.

Function
REQ-016 PC capture: on edge with ctr==0 && enc_vld && enc_new, accumulator pc <= i_trc_pc.
REQ-017 Reg capture: on edge with ctr==0 && dst_reg_wr, accumulator reg_mask[dst_reg] <= 1; bits OR-accumulate across periods of one instruction.
REQ-018 Pred capture: on edge with ctr==0 && run_instr && dst_p, accumulator pred_wr <= !skip.
REQ-019 Retire: done = (&ctr) && run_instr && (!mem_op || mem_op_last); evaluated combinationally each cycle.
REQ-020 On done edge: push {acc pc, acc reg_mask, acc pred_wr, seq_q}, then clear reg_mask and pred_wr; pc held.
REQ-021 seq_q increments by 1 on every done, including dropped pushes; wraps modulo 2^SEQ_W.
REQ-022 Latency: record pushed at edge N is visible on o_trc_rec with o_trc_vld=1 after edge N (no bypass beyond the register).
REQ-023 o_trc_vld = level != 0; o_trc_rec is stable while vld && !rdy.
REQ-024 Full, push without pop: record dropped, FIFO unchanged, o_trc_ovf set next edge.
REQ-025 Full, push with pop in same cycle: both occur, level unchanged, no overflow.
REQ-026 Empty, rdy asserted: no pop, level stays 0; no fall-through of same-cycle push.
REQ-027 o_trc_ovf remains set until an edge with i_trc_ovf_clr=1 and no new overflow; simultaneous overflow and clear leaves it set.
REQ-028 Read/write pointers $clog2(DEPTH) bits, wrap modulo DEPTH; level saturates at DEPTH.

Reset
REQ-029 On i_trc_rst_n low, asynchronously: pointers, level, seq_q, accumulators, o_trc_ovf all zero; o_trc_vld=0.
REQ-030 Reset mid-instruction discards the partial accumulator; first post-reset record has seq=0.
REQ-031 FIFO storage array is not reset; o_trc_rec content undefined while o_trc_vld=0.

Structure
REQ-032 trc_rec_t typedef goes in idli_pkg alongside ctr_t, reg_t, data_t, NUM_REGS; SEQ_W default lives there as TRC_SEQ_W.
REQ-033 FIFO is sub-module idli_trace_fifo_m (parametrised DEPTH, generic payload width), instanced once.
REQ-034 Capture/retire logic stays in idli_trace_m; no combinational path from i_trc_rdy to o_trc_vld.

Verification
REQ-035 One ALU instr, pc=0x0040, r3 written, ctr 0..3 -> one record {pc=0x0040, mask=0x0008, pred_wr=0, seq=0}, vld one edge after ctr==3.
REQ-036 Memory op with 3 periods, mem_op_last only in third, writes r5 -> single record at end of third period, mask=0x0020, seq increments once.
REQ-037 DEPTH=4, rdy=0, 5 retires -> level=4, ovf=1, records seq 0..3 held; rdy=1 drains 0,1,2,3 in order; fifth (seq 4) absent.
REQ-038 Full FIFO, retire coincident with pop -> level stays 4, ovf stays 0, tail record seq=4.
REQ-039 Predicate write with skip=1 then skip=0 on next instr -> pred_wr 0 then 1; ovf_clr asserted alongside an overflow -> ovf remains 1.
REQ-040 Reset asserted at ctr==2 mid-instruction -> all outputs zero immediately; next retire emits seq=0 with empty mask.
